trimmed_mean5_filter: RTL and testbench
=======================================

// Module: trimmed_mean5_filter
// PURPOSE
//  Sequential front end for noisy sensor streams (e.g. ultrasound range bytes).
//  Collects a 5-sample window from a valid-qualified stream.
//  Sorts the window over several cycles and exposes the middle three values.
//  Outputs their floor mean as one filtered sample with a single-cycle valid pulse.
// PARAMETERS
//  WIDTH    8  bits per sample and per output value
//  SLIDING  1  1: window slides by one sample per new sample after the first fill;
//              0: block mode, window empties after each result
// PORTS
//  clock         in   1      system clock; all state changes on rising edge
//  reset_n       in   1      asynchronous reset, active-low
//  clear         in   1      synchronous abort and empty window
//  sample_valid  in   1      sample presented this cycle
//  sample        in   WIDTH  unsigned sample value
//  sample_ready  out  1      block accepts a sample this cycle
//  result_valid  out  1      one-cycle pulse: mid_*/result updated
//  mid_low       out  WIDTH  2nd smallest of window
//  mid_mid       out  WIDTH  median of window
//  mid_high      out  WIDTH  2nd largest of window
//  result        out  WIDTH  floor((mid_low+mid_mid+mid_high)/3)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=FILL, count=0, window regs=0.
//   - sample_ready=1; result_valid=0; mid_*=0; result=0.
//  Accept rule: a sample is accepted on an edge with sample_valid & sample_ready.
//   - Accepted samples shift into w0..w4 (w4 newest, w0 evicted).
//  States:
//   - FILL: sample_ready=1. count increments per accept.
//     On the accept that makes count 5, copy the window into sort regs s0..s4, then go to SORT.
//     The copy includes the incoming sample.
//   - SORT: 5 cycles of odd-even transposition.
//     Even cycles compare-swap (s0,s1),(s2,s3); odd cycles compare-swap (s1,s2),(s3,s4).
//     Swap only if left > right, so the sort is stable and ties are legal.
//     Ends ascending: s0 <= s1 <= ... <= s4.
//   - SUM: 1 cycle. sum = s1+s2+s3 in WIDTH+2 bits; no overflow possible.
//   - DIV: WIDTH+2 cycles restoring division of sum by 3.
//     Quotient is exact floor and always fits in WIDTH bits.
//   - OUT: 1 cycle.
//     Registers mid_low=s1, mid_mid=s2, mid_high=s3, result=quotient.
//     result_valid=1 for this cycle only.
//     Next state: FILL with count=4 if SLIDING=1, or count=0 if SLIDING=0.
//  sample_ready=0 in SORT/SUM/DIV/OUT; upstream must hold the sample or drop it.
//  Latency: accepting edge of completing sample to result_valid high = WIDTH+9 edges (17 for WIDTH=8).
//  Throughput: at most one result per WIDTH+10 cycles.
//  Outputs mid_*/result hold their last value until the next OUT; never change otherwise.
//  clear=1:
//   - Next edge: state=FILL, count=0, sort/div state discarded, sample_ready=1.
//   - No result_valid is issued. mid_*/result hold their values.
//   - clear beats a simultaneous accept: the sample is dropped.
//   - clear in OUT cycle: the OUT updates and pulse still occur that cycle; FILL with count=0 follows.
//  Async reset mid-operation: immediate return to reset values; no partial result escapes.
//  All values unsigned; duplicate samples handled (any equal-value ordering gives same outputs).
// TESTING
//  1. Reset, feed 10,200,50,60,70 back-to-back -> result_valid exactly 17 cycles after 5th accept;
//     mid 50/60/70, result 60.
//  2. Five samples of 255 -> mids 255/255/255, result 255 (sum 765, no overflow); repeat with all 0 -> 0.
//  3. Samples 0,0,1,1,1 -> mids 0/1/1, result 0 (floor of 2/3); samples 3,3,4,9,1 -> 3/3/4, result 3.
//  4. SLIDING=1: after test 1, feed 100 -> window 200,50,60,70,100 -> mids 60/70/100, result 76;
//     SLIDING=0: same -> no result until 4 more samples.
//  5. Assert clear during DIV -> no result_valid; sample_ready=1 next cycle; mid_*/result keep 50/60/70/60;
//     needs 5 fresh samples.
//  6. Drop reset_n during SORT, also hold sample_valid=1 during SORT -> all outputs 0 immediately;
//     held sample not accepted while sample_ready=0.

Source files
------------

// File: rtl/trimmed_mean5_filter.sv
// -----------------------------------------------------------------------------
// trimmed_mean5_filter
//
// Purpose:
//   Sequential trimmed-mean filter for noisy sample streams. It collects a
//   five-sample window from a valid-qualified input stream. It sorts the window
//   over five cycles of odd-even transposition, then divides the sum of the
//   middle three values by 3 with a serial restoring divider. The sorted middle
//   values and the floor mean are published together with a one-cycle valid
//   pulse.
//
// Parameters:
//   WIDTH    bits per sample and per output value
//   SLIDING  1: the window slides by one sample after the first fill
//            0: block mode, five fresh samples per result
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous reset, active low
//   clear         synchronous abort; window count returns to zero
//   sample_valid  input sample is presented this cycle
//   sample        unsigned input sample
//   sample_ready  block accepts a sample this cycle (high only while filling)
//   result_valid  one-cycle pulse; mid_* and result were just updated
//   mid_low       2nd smallest value of the window
//   mid_mid       median of the window
//   mid_high      2nd largest value of the window
//   result        floor((mid_low + mid_mid + mid_high) / 3)
// -----------------------------------------------------------------------------
module trimmed_mean5_filter #(
    parameter int WIDTH   = 8,
    parameter bit SLIDING = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             sample_ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] mid_low,
    output logic [WIDTH-1:0] mid_mid,
    output logic [WIDTH-1:0] mid_high,
    output logic [WIDTH-1:0] result
);

    // The sum of three WIDTH-bit values needs two extra bits.
    localparam int SW        = WIDTH + 2;
    localparam int DIV_STEPS = WIDTH + 2;
    // A single step counter serves both the 5-phase sort and the divider.
    localparam int SCW       = (DIV_STEPS > 5) ? $clog2(DIV_STEPS) : 3;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_SORT,
        ST_SUM,
        ST_DIV,
        ST_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         count_q, count_d;
    logic [WIDTH-1:0]   win_q [5];
    logic [WIDTH-1:0]   win_d [5];
    logic [WIDTH-1:0]   srt_q [5];
    logic [WIDTH-1:0]   srt_d [5];
    logic [SCW-1:0]     step_q, step_d;
    logic [SW-1:0]      dvd_q, dvd_d;
    logic [1:0]         rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;

    logic               result_valid_q, result_valid_d;
    logic [WIDTH-1:0]   mid_low_q, mid_low_d;
    logic [WIDTH-1:0]   mid_mid_q, mid_mid_d;
    logic [WIDTH-1:0]   mid_high_q, mid_high_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               accept;
    logic [2:0]         rem_shift;
    logic [2:0]         rem_sub;

    assign sample_ready = (state_q == ST_FILL);
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        win_d          = win_q;
        srt_d          = srt_q;
        step_d         = step_q;
        dvd_d          = dvd_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        result_valid_d = 1'b0;
        mid_low_d      = mid_low_q;
        mid_mid_d      = mid_mid_q;
        mid_high_d     = mid_high_q;
        result_d       = result_q;
        rem_shift      = {rem_q, dvd_q[SW-1]};
        rem_sub        = rem_shift - 3'd3;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    for (int k = 0; k < 4; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[4] = sample;
                    count_d  = count_q + 3'd1;
                    if (count_q == 3'd4) begin
                        // Snapshot of the window including the incoming sample.
                        for (int k = 0; k < 4; k++) begin
                            srt_d[k] = win_q[k+1];
                        end
                        srt_d[4] = sample;
                        step_d   = '0;
                        state_d  = ST_SORT;
                    end
                end
            end

            ST_SORT: begin
                // Even phases pair (0,1),(2,3); odd phases pair (1,2),(3,4).
                // Pairs within one phase never overlap, so reading srt_q is safe.
                for (int k = 0; k < 4; k++) begin
                    if (((k % 2) == int'(step_q[0])) && (srt_q[k] > srt_q[k+1])) begin
                        srt_d[k]   = srt_q[k+1];
                        srt_d[k+1] = srt_q[k];
                    end
                end
                if (step_q == SCW'(4)) begin
                    state_d = ST_SUM;
                end else begin
                    step_d = step_q + SCW'(1);
                end
            end

            ST_SUM: begin
                dvd_d   = SW'(srt_q[1]) + SW'(srt_q[2]) + SW'(srt_q[3]);
                rem_d   = '0;
                quo_d   = '0;
                step_d  = '0;
                state_d = ST_DIV;
            end

            ST_DIV: begin
                // Restoring division by 3, one dividend bit per cycle, MSB first.
                // The remainder is always < 3, so it fits in two bits.
                dvd_d = dvd_q << 1;
                if (rem_shift >= 3'd3) begin
                    rem_d = rem_sub[1:0];
                    quo_d = WIDTH'({quo_q, 1'b1});
                end else begin
                    rem_d = rem_shift[1:0];
                    quo_d = WIDTH'({quo_q, 1'b0});
                end
                if (step_q == SCW'(DIV_STEPS - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    step_d = step_q + SCW'(1);
                end
            end

            ST_OUT: begin
                mid_low_d      = srt_q[1];
                mid_mid_d      = srt_q[2];
                mid_high_d     = srt_q[3];
                result_d       = quo_q;
                result_valid_d = 1'b1;
                state_d        = ST_FILL;
                count_d        = SLIDING ? 3'd4 : 3'd0;
            end

            default: begin
                state_d = ST_FILL;
                count_d = 3'd0;
            end
        endcase

        // clear wins over a simultaneous accept but leaves an OUT update intact.
        if (clear) begin
            state_d = ST_FILL;
            count_d = 3'd0;
            win_d   = win_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_FILL;
            count_q        <= 3'd0;
            for (int k = 0; k < 5; k++) begin
                win_q[k] <= '0;
                srt_q[k] <= '0;
            end
            step_q         <= '0;
            dvd_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            result_valid_q <= 1'b0;
            mid_low_q      <= '0;
            mid_mid_q      <= '0;
            mid_high_q     <= '0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            win_q          <= win_d;
            srt_q          <= srt_d;
            step_q         <= step_d;
            dvd_q          <= dvd_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            result_valid_q <= result_valid_d;
            mid_low_q      <= mid_low_d;
            mid_mid_q      <= mid_mid_d;
            mid_high_q     <= mid_high_d;
            result_q       <= result_d;
        end
    end

    assign result_valid = result_valid_q;
    assign mid_low      = mid_low_q;
    assign mid_mid      = mid_mid_q;
    assign mid_high     = mid_high_q;
    assign result       = result_q;

endmodule

// File: tb/tb_trimmed_mean5_filter.sv
// -----------------------------------------------------------------------------
// tb_trimmed_mean5_filter
//
// Drives a sliding-mode instance (index 0) and a block-mode instance (index 1)
// from the same input stream. A cycle-level reference model per instance tracks
// the last five accepted samples, the fill count and the busy interval. It
// computes expected outputs by sorting the window and taking the floor mean of
// the middle three values.
// -----------------------------------------------------------------------------
module tb_trimmed_mean5_filter;

    logic       clock;
    logic       reset_n;
    logic       clear;
    logic       sample_valid;
    logic [7:0] sample;

    logic       rdy [2];
    logic       rv  [2];
    logic [7:0] ml  [2];
    logic [7:0] mm  [2];
    logic [7:0] mh  [2];
    logic [7:0] rs  [2];

    int n_cmp;
    int n_err;

    trimmed_mean5_filter #(.WIDTH(8), .SLIDING(1'b1)) u_slide (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (rdy[0]),
        .result_valid (rv[0]),
        .mid_low      (ml[0]),
        .mid_mid      (mm[0]),
        .mid_high     (mh[0]),
        .result       (rs[0])
    );

    trimmed_mean5_filter #(.WIDTH(8), .SLIDING(1'b0)) u_block (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (rdy[1]),
        .result_valid (rv[1]),
        .mid_low      (ml[1]),
        .mid_mid      (mm[1]),
        .mid_high     (mh[1]),
        .result       (rs[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int         mw    [2][5];   // last five accepted samples, index 4 newest
    int         mcnt  [2];
    bit         mbusy [2];
    int         mage  [2];      // edges since the completing accept
    int         pl [2], pm [2], ph [2], pr [2];
    int         el [2], em [2], eh [2], er [2];
    bit         ev [2];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 5; k++) mw[i][k] = 0;
            mcnt[i]  = 0;
            mbusy[i] = 1'b0;
            mage[i]  = 0;
            pl[i] = 0; pm[i] = 0; ph[i] = 0; pr[i] = 0;
            el[i] = 0; em[i] = 0; eh[i] = 0; er[i] = 0;
            ev[i] = 1'b0;
        end
    endtask

    task automatic model_compute(input int i);
        int a [5];
        int t;
        for (int k = 0; k < 5; k++) a[k] = mw[i][k];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 4 - x; y++)
                if (a[y] > a[y+1]) begin
                    t = a[y]; a[y] = a[y+1]; a[y+1] = t;
                end
        pl[i] = a[1];
        pm[i] = a[2];
        ph[i] = a[3];
        pr[i] = (a[1] + a[2] + a[3]) / 3;
    endtask

    // Applies one rising edge with the given inputs to both model instances.
    task automatic model_edge(input bit v, input int d, input bit c);
        for (int i = 0; i < 2; i++) begin
            ev[i] = 1'b0;
            if (mbusy[i]) begin
                mage[i]++;
                if (mage[i] == 17) begin
                    ev[i] = 1'b1;
                    el[i] = pl[i]; em[i] = pm[i]; eh[i] = ph[i]; er[i] = pr[i];
                    mbusy[i] = 1'b0;
                    mcnt[i]  = (c || i == 1) ? 0 : 4;
                end else if (c) begin
                    mbusy[i] = 1'b0;
                    mcnt[i]  = 0;
                end
            end else if (c) begin
                mcnt[i] = 0;
            end else if (v) begin
                for (int k = 0; k < 4; k++) mw[i][k] = mw[i][k+1];
                mw[i][4] = d;
                mcnt[i]++;
                if (mcnt[i] == 5) begin
                    model_compute(i);
                    mbusy[i] = 1'b1;
                    mage[i]  = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("valid%0d", i), int'(rv[i]), int'(ev[i]));
            check_eq($sformatf("ready%0d", i), int'(rdy[i]), int'(!mbusy[i]));
            check_eq($sformatf("mid_low%0d", i), int'(ml[i]), el[i]);
            check_eq($sformatf("mid_mid%0d", i), int'(mm[i]), em[i]);
            check_eq($sformatf("mid_high%0d", i), int'(mh[i]), eh[i]);
            check_eq($sformatf("result%0d", i), int'(rs[i]), er[i]);
        end
    endtask

    task automatic step(input bit v, input int d, input bit c);
        @(negedge clock);
        sample_valid = v;
        sample       = 8'(d);
        clear        = c;
        @(posedge clock);
        model_edge(v, d, c);
        #1;
        compare_all();
    endtask

    task automatic feed(input int d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 0, 1'b1);
    endtask

    task automatic feed5(input int a, input int b, input int c, input int d, input int e);
        feed(a); feed(b); feed(c); feed(d); feed(e);
    endtask

    task automatic expect0(input string tag, input int l, input int m, input int h, input int r);
        check_eq({tag, "_valid"}, int'(rv[0]), 1);
        check_eq({tag, "_low"},   int'(ml[0]), l);
        check_eq({tag, "_mid"},   int'(mm[0]), m);
        check_eq({tag, "_high"},  int'(mh[0]), h);
        check_eq({tag, "_res"},   int'(rs[0]), r);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset_n      = 1'b1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'd0;
        model_reset();
        #2 reset_n = 1'b0;
        #1 compare_all();
        @(negedge clock);
        reset_n = 1'b1;

        // Test 1: basic window, latency of 17 edges after the fifth accept.
        feed5(10, 200, 50, 60, 70);
        idle(16);
        check_eq("t1_early", int'(rv[0]), 0);
        idle(1);
        expect0("t1", 50, 60, 70, 60);
        idle(1);
        check_eq("t1_pulse_len", int'(rv[0]), 0);

        // Test 4: sliding window produces a result on one new sample.
        feed(100);
        idle(17);
        expect0("t4", 60, 70, 100, 76);
        check_eq("t4_block_quiet", int'(rv[1]), 0);

        // Test 2: full-scale and zero windows.
        do_clear();
        feed5(255, 255, 255, 255, 255);
        idle(17);
        expect0("t2a", 255, 255, 255, 255);
        do_clear();
        feed5(0, 0, 0, 0, 0);
        idle(17);
        expect0("t2b", 0, 0, 0, 0);

        // Test 3: duplicates and floor rounding.
        do_clear();
        feed5(0, 0, 1, 1, 1);
        idle(17);
        expect0("t3a", 0, 1, 1, 0);
        do_clear();
        feed5(3, 3, 4, 9, 1);
        idle(17);
        expect0("t3b", 3, 3, 4, 3);

        // Test 5: clear during DIV aborts the result and keeps old outputs.
        do_clear();
        feed5(10, 200, 50, 60, 70);
        idle(17);
        feed5(1, 2, 3, 4, 5);
        idle(10);
        do_clear();
        check_eq("t5_ready", int'(rdy[0]), 1);
        idle(20);
        check_eq("t5_res", int'(rs[0]), 60);
        check_eq("t5_mid", int'(mm[0]), 60);

        // Test 7: clear in the OUT cycle still publishes the result.
        feed5(7, 8, 9, 10, 11);
        idle(16);
        do_clear();
        expect0("t7", 8, 9, 10, 9);
        idle(20);

        // Test 6: async reset during SORT with sample_valid held high.
        do_clear();
        feed5(40, 41, 42, 43, 44);
        step(1'b1, 99, 1'b0);
        step(1'b1, 99, 1'b0);
        #2;
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("t6_ready", int'(rdy[0]), 1);
        check_eq("t6_res", int'(rs[0]), 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(25);

        // Randomized traffic with duplicates and occasional clears.
        for (int n = 0; n < 3000; n++) begin
            bit v;
            bit c;
            int d;
            v = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 149) == 0);
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 255));
            step(v, d, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
